// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - opcodes, write-back select, queue entry type and opcode decode
package wb_pkg;

   // Widest result the queue entries carry; the top zero-extends narrower XLEN into it
   localparam int WB_DATA_W = 64;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUW   = 7'b0111011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_ALUIW  = 7'b0011011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_LOAD = 2'd2,
      WB_LINK = 2'd3
   } wb_sel_e;

   typedef struct packed {
      logic [4:0]           rd;
      wb_sel_e              wb_sel;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

   // Which result (if any) an instruction writes back to the register file
   function automatic wb_sel_e wb_decode(input logic [6:0] opcode);
      case (opcode)
         OP_ALU, OP_ALUW, OP_ALUI, OP_ALUIW, OP_AUIPC, OP_LUI: wb_decode = WB_ALU;
         OP_LOAD:                                              wb_decode = WB_LOAD;
         OP_JAL, OP_JALR:                                      wb_decode = WB_LINK;
         OP_STORE, OP_BRANCH, OP_FENCE, OP_SYSTEM:             wb_decode = WB_NONE;
         default:                                              wb_decode = WB_NONE;
      endcase
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source completion queue with count register and flush
module wb_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic push,
   input  T     wdata,
   input  logic pop,
   output T     rdata,
   output logic full,
   output logic empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T               r_mem [DEPTH];
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [AW:0]    r_count;
   logic           w_do_push;
   logic           w_do_pop;

   // A full queue refuses a push even when it is popped in the same cycle
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;
   assign full      = (r_count == (AW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign rdata     = r_mem[r_rptr];

   // Pointers wrap naturally because DEPTH is a power of two; flush empties like reset
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; a dropped push must not overwrite a live slot either
   always_ff @(posedge clk) begin
      if (w_do_push && !reset && !flush) r_mem[r_wptr] <= wdata;
   end

endmodule

// File: rtl/multi_source_writeback.sv
// rtl/multi_source_writeback.sv - round-robin retire of per-source completion queues onto one RF write port
module multi_source_writeback
   import wb_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic [NUM_SRC-1:0]      src_valid,
   output logic [NUM_SRC-1:0]      src_ready,
   input  logic [NUM_SRC*7-1:0]    src_opcode,
   input  logic [NUM_SRC*5-1:0]    src_rd,
   input  logic [NUM_SRC*XLEN-1:0] src_alu,
   input  logic [NUM_SRC*XLEN-1:0] src_load,
   input  logic [NUM_SRC*XLEN-1:0] src_pc,
   output logic                    rf_we,
   output logic [4:0]              rf_waddr,
   output logic [XLEN-1:0]         rf_wdata,
   output logic                    retire_valid,
   output logic [SRC_W-1:0]        retire_src
);

   wb_entry_t           w_in   [NUM_SRC];
   wb_entry_t           w_head [NUM_SRC];
   logic [NUM_SRC-1:0]  w_full;
   logic [NUM_SRC-1:0]  w_empty;
   logic [NUM_SRC-1:0]  w_push;
   logic [NUM_SRC-1:0]  w_pop;

   logic                w_grant_vld;
   logic [SRC_W-1:0]    w_grant;
   logic                w_retire;
   logic                w_we;
   wb_entry_t           w_sel_entry;

   logic [SRC_W-1:0]    r_rr;
   logic                r_we;
   logic [4:0]          r_waddr;
   logic [XLEN-1:0]     r_wdata;
   logic                r_retire_valid;
   logic [SRC_W-1:0]    r_retire_src;

   assign src_ready = ~w_full;

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_src
         wb_sel_e         w_sel;
         logic [XLEN-1:0] w_data;

         // The write-back value is chosen at enqueue so the queue only stores one result
         always_comb begin
            w_sel  = wb_decode(src_opcode[g*7 +: 7]);
            w_data = '0;
            case (w_sel)
               WB_ALU:  w_data = src_alu[g*XLEN +: XLEN];
               WB_LOAD: w_data = src_load[g*XLEN +: XLEN];
               WB_LINK: w_data = src_pc[g*XLEN +: XLEN] + XLEN'(4);
               default: w_data = '0;
            endcase
         end

         assign w_in[g].rd     = src_rd[g*5 +: 5];
         assign w_in[g].wb_sel = w_sel;
         assign w_in[g].data   = WB_DATA_W'(w_data);
         assign w_push[g]      = src_valid[g] & ~w_full[g];
         assign w_pop[g]       = w_retire & (w_grant == SRC_W'(g));

         wb_fifo #(
            .T     (wb_entry_t),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .push  (w_push[g]),
            .wdata (w_in[g]),
            .pop   (w_pop[g]),
            .rdata (w_head[g]),
            .full  (w_full[g]),
            .empty (w_empty[g])
         );
      end
   endgenerate

   // First non-empty queue at or after the round-robin pointer wins
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant     = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         int idx;
         idx = (int'(r_rr) + k) % NUM_SRC;
         if (!w_grant_vld && !w_empty[idx]) begin
            w_grant_vld = 1'b1;
            w_grant     = SRC_W'(idx);
         end
      end
   end

   // A flush cycle retires nothing, so the granted entry is simply discarded with the rest
   assign w_retire    = w_grant_vld & ~flush;
   assign w_sel_entry = w_head[w_grant];
   assign w_we        = w_retire && (w_sel_entry.wb_sel != WB_NONE) && (w_sel_entry.rd != 5'd0);

   // Output register and round-robin pointer; pointer only moves past a real grant
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr           <= '0;
         r_we           <= 1'b0;
         r_waddr        <= '0;
         r_wdata        <= '0;
         r_retire_valid <= 1'b0;
         r_retire_src   <= '0;
      end else begin
         r_retire_valid <= w_retire;
         r_retire_src   <= w_retire ? w_grant : '0;
         r_we           <= w_we;
         r_waddr        <= w_we ? w_sel_entry.rd : 5'd0;
         r_wdata        <= w_we ? w_sel_entry.data[XLEN-1:0] : '0;
         if (w_retire) begin
            r_rr <= (w_grant == SRC_W'(NUM_SRC-1)) ? '0 : w_grant + 1'b1;
         end
      end
   end

   assign rf_we        = r_we;
   assign rf_waddr     = r_waddr;
   assign rf_wdata     = r_wdata;
   assign retire_valid = r_retire_valid;
   assign retire_src   = r_retire_src;

endmodule

// File: tb/tb_multi_source_writeback.sv
// tb/tb_multi_source_writeback.sv - scoreboard bench for multi_source_writeback
module tb_multi_source_writeback;

   localparam int XLEN    = 64;
   localparam int NUM_SRC = 2;
   localparam int DEPTH   = 2;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    flush;
   logic [NUM_SRC-1:0]      src_valid;
   logic [NUM_SRC-1:0]      src_ready;
   logic [NUM_SRC*7-1:0]    src_opcode;
   logic [NUM_SRC*5-1:0]    src_rd;
   logic [NUM_SRC*XLEN-1:0] src_alu;
   logic [NUM_SRC*XLEN-1:0] src_load;
   logic [NUM_SRC*XLEN-1:0] src_pc;
   logic                    rf_we;
   logic [4:0]              rf_waddr;
   logic [XLEN-1:0]         rf_wdata;
   logic                    retire_valid;
   logic [0:0]              retire_src;

   multi_source_writeback #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .src_opcode   (src_opcode),
      .src_rd       (src_rd),
      .src_alu      (src_alu),
      .src_load     (src_load),
      .src_pc       (src_pc),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .retire_valid (retire_valid),
      .retire_src   (retire_src)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [63:0] wdata;
   } exp_t;

   exp_t       q0[$];
   exp_t       q1[$];
   int         src_log[$];
   exp_t       stage[2];
   logic [1:0] last_acc;
   int         checks   = 0;
   int         failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every retire pops the expected entry of the reported source
   always @(negedge clk) begin
      if (reset === 1'b0 && retire_valid === 1'b1) begin
         exp_t e;
         logic found;
         found = 1'b0;
         src_log.push_back(int'(retire_src));
         if (retire_src == 1'b0 && q0.size() > 0) begin
            e = q0.pop_front(); found = 1'b1;
         end else if (retire_src == 1'b1 && q1.size() > 0) begin
            e = q1.pop_front(); found = 1'b1;
         end
         if (!found) begin
            checks++;
            failures++;
            $display("FAIL unexpected_retire actual=src%0d waddr=%0d required=no_retire", retire_src, rf_waddr);
         end else begin
            chk("sb_rf_we", 64'(rf_we), 64'(e.we));
            chk("sb_rf_waddr", 64'(rf_waddr), 64'(e.waddr));
            chk("sb_rf_wdata", rf_wdata, e.wdata);
         end
      end
   end

   task automatic set_src(input int s, input logic [6:0] op, input logic [4:0] rd,
                          input logic [63:0] alu, input logic [63:0] load, input logic [63:0] pc,
                          input logic we, input logic [4:0] waddr, input logic [63:0] wdata);
      src_opcode[s*7 +: 7]     = op;
      src_rd[s*5 +: 5]         = rd;
      src_alu[s*XLEN +: XLEN]  = alu;
      src_load[s*XLEN +: XLEN] = load;
      src_pc[s*XLEN +: XLEN]   = pc;
      stage[s]                 = '{we: we, waddr: waddr, wdata: wdata};
   endtask

   // Present valids for one cycle; accepted pushes become scoreboard expectations
   task automatic step(input logic [1:0] vmask);
      logic [1:0] acc;
      src_valid = vmask;
      acc       = vmask & src_ready;
      @(posedge clk); #1;
      if (!reset && !flush) begin
         if (acc[0]) q0.push_back(stage[0]);
         if (acc[1]) q1.push_back(stage[1]);
         last_acc = acc;
      end else begin
         last_acc = 2'b00;
      end
      src_valid = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n1, guard;
      logic saw_not_ready;
      reset = 1'b1; flush = 1'b0; src_valid = '0;
      src_opcode = '0; src_rd = '0; src_alu = '0; src_load = '0; src_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // 1: reset state and idle
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_rf_wdata", rf_wdata, 64'd0);
      chk("rst_retire_src", 64'(retire_src), 64'd0);
      chk("rst_src_ready", 64'(src_ready), 64'd3);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("idle_retire_valid", 64'(retire_valid), 64'd0);
      end

      // 2: ADD rd=5 -> write 0x1234 two edges after the push is presented
      set_src(0, 7'b0110011, 5'd5, 64'h1234, 64'hDEAD, 64'h100, 1'b1, 5'd5, 64'h1234);
      step(2'b01);
      chk("lat_edge1_retire_valid", 64'(retire_valid), 64'd0);
      @(posedge clk); #1;
      chk("lat_edge2_retire_valid", 64'(retire_valid), 64'd1);
      chk("lat_edge2_rf_we", 64'(rf_we), 64'd1);
      chk("lat_edge2_retire_src", 64'(retire_src), 64'd0);
      idle(3);

      // 3: JAL link wraps, store retires without write, rd=0 suppresses write, JALR/LUI/load/branch
      set_src(0, 7'b1101111, 5'd1, 64'h55, 64'h66, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 5'd1, 64'h0);
      set_src(1, 7'b0100011, 5'd3, 64'h77, 64'h88, 64'h200, 1'b0, 5'd0, 64'h0);
      step(2'b11);
      set_src(0, 7'b0110011, 5'd0, 64'h99, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0);
      set_src(1, 7'b1100111, 5'd2, 64'h11, 64'h22, 64'h1000, 1'b1, 5'd2, 64'h1004);
      step(2'b11);
      set_src(0, 7'b0110111, 5'd9, 64'hABCD_0000, 64'h1, 64'h2, 1'b1, 5'd9, 64'hABCD_0000);
      set_src(1, 7'b0000011, 5'd4, 64'h3, 64'hCAFE, 64'h4, 1'b1, 5'd4, 64'hCAFE);
      step(2'b11);
      set_src(0, 7'b1100011, 5'd6, 64'h5, 64'h6, 64'h7, 1'b0, 5'd0, 64'h0);
      step(2'b01);
      idle(6);

      // 4: both sources stream; retires alternate starting at src1 (pointer left at 1)
      src_log.delete();
      n0 = 0; n1 = 0; guard = 0; saw_not_ready = 1'b0;
      while ((n0 < 4 || n1 < 4) && guard < 40) begin
         set_src(0, 7'b0010011, 5'(8 + n0), 64'(32'hA0 + n0), 64'h0, 64'h0, 1'b1, 5'(8 + n0), 64'(32'hA0 + n0));
         set_src(1, 7'b0010011, 5'(16 + n1), 64'(32'hB0 + n1), 64'h0, 64'h0, 1'b1, 5'(16 + n1), 64'(32'hB0 + n1));
         if (src_ready != 2'b11) saw_not_ready = 1'b1;
         step({logic'(n1 < 4), logic'(n0 < 4)});
         n0 += int'(last_acc[0]);
         n1 += int'(last_acc[1]);
         guard++;
      end
      chk("stream_all_accepted", 64'(n0 + n1), 64'd8);
      chk("stream_ready_dropped", 64'(saw_not_ready), 64'd1);
      idle(8);
      chk("stream_retire_count", 64'(src_log.size()), 64'd8);
      for (int i = 0; i < src_log.size(); i++) begin
         chk("stream_alternation", 64'(src_log[i]), 64'((i + 1) % 2));
      end

      // 5: fill, flush one cycle, nothing more retires, then a load goes through
      set_src(0, 7'b0110011, 5'd12, 64'h12, 64'h0, 64'h0, 1'b1, 5'd12, 64'h12);
      set_src(1, 7'b0110011, 5'd13, 64'h13, 64'h0, 64'h0, 1'b1, 5'd13, 64'h13);
      step(2'b11);
      step(2'b11);
      step(2'b11);
      chk("fill_full", 64'(src_ready), 64'd1);
      flush = 1'b1;
      step(2'b11);
      flush = 1'b0;
      q0.delete(); q1.delete();
      chk("flush_retire_valid", 64'(retire_valid), 64'd0);
      chk("flush_rf_we", 64'(rf_we), 64'd0);
      chk("flush_src_ready", 64'(src_ready), 64'd3);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("post_flush_retire_valid", 64'(retire_valid), 64'd0);
      end
      set_src(0, 7'b0000011, 5'd7, 64'h1, 64'hAB, 64'h2, 1'b1, 5'd7, 64'hAB);
      step(2'b01);
      @(posedge clk); #1;
      chk("flush_load_wdata", rf_wdata, 64'hAB);
      idle(3);

      // 6: reset with three entries queued and flush asserted together
      set_src(0, 7'b0110011, 5'd24, 64'h24, 64'h0, 64'h0, 1'b1, 5'd24, 64'h24);
      set_src(1, 7'b0110011, 5'd25, 64'h25, 64'h0, 64'h0, 1'b1, 5'd25, 64'h25);
      step(2'b11);
      step(2'b11);
      reset = 1'b1; flush = 1'b1;
      step(2'b11);
      q0.delete(); q1.delete();
      chk("rst_mid_retire_valid", 64'(retire_valid), 64'd0);
      chk("rst_mid_rf_we", 64'(rf_we), 64'd0);
      chk("rst_mid_rf_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_mid_rf_wdata", rf_wdata, 64'd0);
      chk("rst_mid_src_ready", 64'(src_ready), 64'd3);
      reset = 1'b0; flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_mid_empty", 64'(retire_valid), 64'd0);
      end
      set_src(0, 7'b0110011, 5'd20, 64'h20, 64'h0, 64'h0, 1'b1, 5'd20, 64'h20);
      set_src(1, 7'b0110011, 5'd21, 64'h21, 64'h0, 64'h0, 1'b1, 5'd21, 64'h21);
      step(2'b11);
      @(posedge clk); #1;
      chk("rst_rr_first_valid", 64'(retire_valid), 64'd1);
      chk("rst_rr_first_src", 64'(retire_src), 64'd0);
      idle(4);

      chk("sb_q0_drained", 64'(q0.size()), 64'd0);
      chk("sb_q1_drained", 64'(q1.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
